generic_rr_pkt_arb: RTL and testbench
=====================================

GENERIC_RR_PKT_ARB -- requirements
Module: generic_rr_pkt_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of requesters, minimum 1.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload width per requester.
REQ-003 SHALL have parameter SIZE, default $clog2(WIDTH) (1 when WIDTH=1): width of the encoded source index.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port cfg_req_en  input  WIDTH: per-requester enable; a disabled requester never wins arbitration.
REQ-007 SHALL have port in_valid  input  WIDTH: per-requester beat valid.
REQ-008 SHALL have port in_data  input  WIDTH x DATA_WIDTH: per-requester beat payload.
REQ-009 SHALL have port in_last  input  WIDTH: per-requester end-of-packet marker.
REQ-010 SHALL have port in_ready  output  WIDTH: per-requester accept; one-hot or zero.
REQ-011 SHALL have port out_valid  output  1: output beat valid.
REQ-012 SHALL have port out_data  output  DATA_WIDTH: output payload.
REQ-013 SHALL have port out_last  output  1: output end-of-packet.
REQ-014 SHALL have port out_src  output  SIZE: index of current owner.
REQ-015 SHALL have port out_ready  input  1: downstream accept.
REQ-016 SHALL have port busy  output  1: high while a packet lock is held.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and LOCKED.
REQ-018 In IDLE, candidates = in_valid & cfg_req_en; no beat transfers; in_ready = 0, out_valid = 0.
REQ-019 In IDLE with any candidate, SHALL select the winner round-robin and enter LOCKED next cycle with owner = winner; arbitration latency exactly 1 cycle.
REQ-020 Round-robin: masked candidates = candidates with index strictly above last_owner; winner = lowest set masked bit, else lowest set candidate bit (wrap-around).
REQ-021 In LOCKED, out_valid = in_valid[owner], out_data = in_data[owner], out_last = in_last[owner], in_ready[owner] = out_ready, all other in_ready bits 0.
REQ-022 A beat transfers when out_valid and out_ready are both high in LOCKED.
REQ-023 Transfer with out_last = 1 SHALL return FSM to IDLE and set last_owner = owner; the next grant follows after one IDLE cycle (one bubble).
REQ-024 Owner deasserting in_valid mid-packet SHALL NOT release the lock; out_valid simply drops.
REQ-025 Deasserting cfg_req_en[owner] mid-packet SHALL NOT release the lock; enable is sampled only at arbitration.
REQ-026 out_src and busy SHALL be registered: out_src = owner in LOCKED, 0 in IDLE; busy = 1 exactly when in LOCKED.
REQ-027 When WIDTH = 1, arbitration degenerates to requester 0; the FSM is unchanged.
REQ-028 out_data SHALL be 0 whenever out_valid = 0.

Reset
REQ-029 Reset SHALL force IDLE, owner = 0, last_owner = WIDTH-1 (requester 0 has first priority), busy = 0, out_src = 0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet immediately; no in_ready or out_valid in the reset cycle or the following cycle.

Structure
REQ-031 Shared package SHALL hold the FSM state enum (IDLE, LOCKED); no other shared types required.
REQ-032 SHALL instantiate generic_ffs_fast twice (DIR_L2H = 1): once on masked candidates, once on unmasked candidates; mask derived from thermometer of last_owner.
REQ-033 Datapath mux SHALL be indexed by registered owner, not by combinational winner.
REQ-034 Expected size 120-250 lines RTL.

Verification
REQ-035 WIDTH=4, after reset, in_valid=4'b1010, all last=1, out_ready=1 -> grants 1 then 3 then 1; one bubble cycle between packets.
REQ-036 All four valid and enabled, single-beat packets, out_ready=1 -> out_src sequence 0,1,2,3,0; in_ready one-hot each LOCKED cycle.
REQ-037 Owner 2 sends 3-beat packet with out_ready toggling 1,0,1,1 and requester 0 valid throughout -> all 3 beats of 2 delivered in order, no interleave, busy=1 for 4 cycles, then owner 0.
REQ-038 cfg_req_en=4'b1011, in_valid=4'b0100 -> busy stays 0, in_ready stays 0; enabling bit 2 -> LOCKED next cycle with out_src=2.
REQ-039 Reset asserted on second beat of a 4-beat packet -> next cycle busy=0, out_valid=0; after reset requester 0 wins first when 0 and 3 both valid.
REQ-040 Owner drops in_valid for 2 cycles mid-packet -> out_valid=0 those cycles, busy stays 1, lock retained until its last beat.

Source files
------------

// File: rtl/generic_rr_pkt_arb_pkg.sv
// Shared types for the round-robin packet arbiter.
// Holds the lock FSM state encoding.
package generic_rr_pkt_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/generic_ffs_fast.sv
// Find-first-set: reports whether any bit is set and its index.
// DIR_L2H=1 picks the lowest set bit, otherwise the highest.
module generic_ffs_fast #(
  parameter int WIDTH   = 4,
  parameter int SIZE    = 2,
  parameter bit DIR_L2H = 1'b1
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [SIZE-1:0]  index_o
);

  always_comb begin
    valid_o = |data_i;
    index_o = '0;
    if (DIR_L2H) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (data_i[i]) index_o = SIZE'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (data_i[i]) index_o = SIZE'(i);
      end
    end
  end

endmodule

// File: rtl/generic_rr_pkt_arb.sv
// Round-robin packet arbiter: grants one requester per packet
// and holds the lock until that requester's last beat transfers.
module generic_rr_pkt_arb #(
  parameter int WIDTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [WIDTH-1:0]                cfg_req_en,
  input  logic [WIDTH-1:0]                in_valid,
  input  logic [WIDTH-1:0][DATA_WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0]                in_last,
  output logic [WIDTH-1:0]                in_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_last,
  output logic [SIZE-1:0]                 out_src,
  input  logic                            out_ready,
  output logic                            busy
);

  import generic_rr_pkt_arb_pkg::*;

  arb_state_e      state_q, state_d;
  logic [SIZE-1:0] owner_q, owner_d;
  logic [SIZE-1:0] last_q, last_d;
  logic [SIZE-1:0] src_q, src_d;
  logic            busy_q, busy_d;

  logic [WIDTH-1:0] cand, mask, cand_m;
  logic             hit_m, hit_u;
  logic [SIZE-1:0]  idx_m, idx_u, winner;

  logic                  sel_valid, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  locked, xfer;

  // Thermometer: only indices strictly above the last owner.
  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (i > int'(last_q));
    end
  end

  assign cand   = in_valid & cfg_req_en;
  assign cand_m = cand & mask;

  generic_ffs_fast #(
    .WIDTH   (WIDTH),
    .SIZE    (SIZE),
    .DIR_L2H (1'b1)
  ) u_ffs_masked (
    .data_i  (cand_m),
    .valid_o (hit_m),
    .index_o (idx_m)
  );

  generic_ffs_fast #(
    .WIDTH   (WIDTH),
    .SIZE    (SIZE),
    .DIR_L2H (1'b1)
  ) u_ffs_unmasked (
    .data_i  (cand),
    .valid_o (hit_u),
    .index_o (idx_u)
  );

  assign winner = hit_m ? idx_m : idx_u;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (owner_q == SIZE'(i)) begin
        sel_valid = in_valid[i];
        sel_last  = in_last[i];
        sel_data  = in_data[i];
      end
    end
  end

  // Reset kills the packet in the same cycle it is raised.
  assign locked    = (state_q == LOCKED) && !reset;
  assign out_valid = locked && sel_valid;
  assign out_data  = out_valid ? sel_data : '0;
  assign out_last  = locked && sel_last;
  assign xfer      = out_valid && out_ready;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < WIDTH; i++) begin
      in_ready[i] = locked && out_ready && (owner_q == SIZE'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|cand) begin
          state_d = LOCKED;
          owner_d = winner;
        end
      end
      LOCKED: begin
        if (xfer && sel_last) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOCKED);
    src_d  = busy_d ? owner_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= SIZE'(WIDTH - 1);
      src_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      src_q   <= src_d;
      busy_q  <= busy_d;
    end
  end

  assign out_src = src_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_generic_rr_pkt_arb.sv
// Bench for the round-robin packet arbiter: a rotating-scan
// reference model checked every cycle plus directed scenarios.
module tb_generic_rr_pkt_arb;

  localparam int W  = 4;
  localparam int DW = 32;
  localparam int SZ = 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [W-1:0]            cfg_req_en = '0;
  logic [W-1:0]            in_valid = '0;
  logic [W-1:0][DW-1:0]    in_data = '0;
  logic [W-1:0]            in_last = '0;
  logic [W-1:0]            in_ready;
  logic                    out_valid;
  logic [DW-1:0]           out_data;
  logic                    out_last;
  logic [SZ-1:0]           out_src;
  logic                    out_ready = 1'b0;
  logic                    busy;

  generic_rr_pkt_arb #(
    .WIDTH      (W),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_req_en (cfg_req_en),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit  m_lock = 1'b0;
  int  m_owner = 0;
  int  m_lastown = W - 1;
  int  cyc = 0;
  int  run = 0;
  int  last_run = 0;

  int            xq_src[$];
  logic [DW-1:0] xq_data[$];
  int            xq_cyc[$];

  bit            e_act;
  logic          e_valid, e_last, e_busy;
  logic [W-1:0]  e_ready;
  logic [DW-1:0] e_data;
  logic [SZ-1:0] e_src;
  int            w;

  always @(negedge clk) begin
    e_act   = m_lock && !reset;
    e_valid = e_act && in_valid[m_owner];
    e_last  = e_act && in_last[m_owner];
    e_ready = (e_act && out_ready) ? W'(1 << m_owner) : '0;
    e_data  = e_valid ? in_data[m_owner] : '0;
    e_busy  = m_lock;
    e_src   = m_lock ? SZ'(m_owner) : '0;
    chk("out_valid", out_valid, e_valid);
    chk("out_last", out_last, e_last);
    chk("in_ready", in_ready, e_ready);
    chk("out_data", out_data, e_data);
    chk("busy", busy, e_busy);
    chk("out_src", out_src, e_src);
    if (busy === 1'b1) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    if (out_valid === 1'b1 && out_ready) begin
      xq_src.push_back(int'(out_src));
      xq_data.push_back(out_data);
      xq_cyc.push_back(cyc);
    end
    // Advance the model to what the next rising edge produces.
    if (reset) begin
      m_lock = 1'b0;
      m_owner = 0;
      m_lastown = W - 1;
    end else if (!m_lock) begin
      w = -1;
      for (int k = 1; k <= W; k++) begin
        if (w < 0 && in_valid[(m_lastown + k) % W]
            && cfg_req_en[(m_lastown + k) % W])
          w = (m_lastown + k) % W;
      end
      if (w >= 0) begin
        m_lock = 1'b1;
        m_owner = w;
      end
    end else if (in_valid[m_owner] && out_ready && in_last[m_owner]) begin
      m_lock = 1'b0;
      m_lastown = m_owner;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = '0;
    in_last = '0;
    out_ready = 1'b0;
    cfg_req_en = '0;
    ticks(2);
    reset = 1'b0;
    xq_src.delete();
    xq_data.delete();
    xq_cyc.delete();
    chk("rst_busy", busy, 1'b0);
    chk("rst_src", out_src, '0);
  endtask

  task automatic chk_x(input string name, input int idx,
                       input int src);
    if (idx >= xq_src.size()) begin
      checks++;
      failures++;
      $display("FAIL %s missing transfer %0d (have %0d)",
               name, idx, xq_src.size());
    end else begin
      chk(name, xq_src[idx], src);
    end
  endtask

  task automatic chk_gap(input string name, input int idx,
                         input int gap);
    if (idx + 1 >= xq_cyc.size()) begin
      checks++;
      failures++;
      $display("FAIL %s missing transfer %0d", name, idx + 1);
    end else begin
      chk(name, xq_cyc[idx+1] - xq_cyc[idx], gap);
    end
  endtask

  task automatic chk_d(input string name, input int idx,
                       input logic [DW-1:0] d);
    if (idx >= xq_data.size()) begin
      checks++;
      failures++;
      $display("FAIL %s missing transfer %0d", name, idx);
    end else begin
      chk(name, xq_data[idx], d);
    end
  endtask

  initial begin
    for (int i = 0; i < W; i++) in_data[i] = 32'hD000_0000 | (i << 8);

    // Alternating pair: 1, 3, 1 with one bubble between packets
    do_reset();
    cfg_req_en = 4'b1111;
    in_valid = 4'b1010;
    in_last = 4'b1111;
    out_ready = 1'b1;
    ticks(7);
    chk_x("alt_g0", 0, 1);
    chk_x("alt_g1", 1, 3);
    chk_x("alt_g2", 2, 1);
    chk_gap("alt_gap0", 0, 2);
    chk_gap("alt_gap1", 1, 2);

    // All four requesting single-beat packets
    do_reset();
    cfg_req_en = 4'b1111;
    in_valid = 4'b1111;
    in_last = 4'b1111;
    out_ready = 1'b1;
    ticks(10);
    for (int i = 0; i < 5; i++) chk_x("rr4", i, i % 4);

    // Multi-beat packet from 2 with backpressure, 0 waiting
    do_reset();
    cfg_req_en = 4'b1111;
    out_ready = 1'b1;
    in_valid = 4'b0100;
    in_last = 4'b0001;
    in_data[0] = 32'hA0;
    in_data[2] = 32'hB0;
    tick();
    in_valid = 4'b0101;
    tick();
    out_ready = 1'b0;
    in_data[2] = 32'hB1;
    tick();
    out_ready = 1'b1;
    tick();
    in_data[2] = 32'hB2;
    in_last = 4'b0101;
    tick();
    in_valid = 4'b0001;
    tick();
    chk("pkt_busy_run", last_run, 4);
    tick();
    in_valid = 4'b0000;
    ticks(2);
    chk_x("pkt_s0", 0, 2);
    chk_x("pkt_s1", 1, 2);
    chk_x("pkt_s2", 2, 2);
    chk_x("pkt_next", 3, 0);
    chk_d("pkt_d0", 0, 32'hB0);
    chk_d("pkt_d1", 1, 32'hB1);
    chk_d("pkt_d2", 2, 32'hB2);
    chk_d("pkt_d3", 3, 32'hA0);

    // Disabled requester never wins until enabled
    do_reset();
    cfg_req_en = 4'b1011;
    in_valid = 4'b0100;
    in_last = 4'b1111;
    out_ready = 1'b1;
    ticks(3);
    chk("dis_busy", busy, 1'b0);
    chk("dis_ready", in_ready, 4'b0000);
    cfg_req_en = 4'b1111;
    tick();
    chk("en_busy", busy, 1'b1);
    chk("en_src", out_src, 2'd2);
    in_valid = 4'b0000;
    ticks(2);

    // Reset on the second beat of a packet from 3
    do_reset();
    cfg_req_en = 4'b1111;
    out_ready = 1'b1;
    in_valid = 4'b1000;
    in_last = 4'b0000;
    ticks(2);
    reset = 1'b1;
    #1;
    chk("rstmid_ready", in_ready, 4'b0000);
    chk("rstmid_valid", out_valid, 1'b0);
    tick();
    reset = 1'b0;
    in_valid = 4'b1001;
    in_last = 4'b1111;
    #1;
    chk("post_busy", busy, 1'b0);
    chk("post_valid", out_valid, 1'b0);
    tick();
    chk("post_src", out_src, 2'd0);
    chk("post_lock", busy, 1'b1);
    in_valid = 4'b0000;
    ticks(2);

    // Owner stalls; enable and valid from others must not steal
    do_reset();
    cfg_req_en = 4'b1111;
    out_ready = 1'b1;
    in_valid = 4'b0010;
    in_last = 4'b0000;
    ticks(2);
    in_valid = 4'b1000;
    cfg_req_en = 4'b1101;
    tick();
    chk("stall_valid", out_valid, 1'b0);
    chk("stall_busy", busy, 1'b1);
    tick();
    in_valid = 4'b0010;
    in_last = 4'b0010;
    tick();
    in_valid = 4'b0000;
    ticks(2);
    chk_x("stall_s0", 0, 1);
    chk_x("stall_s1", 1, 1);
    chk("stall_n", xq_src.size(), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
